// File: rtl/sprite_renderer_if.sv
// sprite_renderer_if: scan position, sprite placement, animation controls and
// the registered sheet address / hit outputs of one sprite layer.
// master = the video timing / sprite control side, slave = the renderer.
interface sprite_renderer_if #(
  parameter int ADDR_W = 17,
  parameter int FIDX_W = 3
);
  logic              frame_tick;
  logic [9:0]        h_cnt;
  logic [9:0]        v_cnt;
  logic [8:0]        sprite_x;
  logic [8:0]        sprite_y;
  logic [8:0]        base_x;
  logic [8:0]        base_y;
  logic              anim_en;
  logic              anim_rst;
  logic              flip;
  logic [ADDR_W-1:0] pixel_addr;
  logic              is_object;
  logic [FIDX_W-1:0] frame_idx;

  modport master (
    output frame_tick, h_cnt, v_cnt, sprite_x, sprite_y, base_x, base_y,
           anim_en, anim_rst, flip,
    input  pixel_addr, is_object, frame_idx
  );

  modport slave (
    input  frame_tick, h_cnt, v_cnt, sprite_x, sprite_y, base_x, base_y,
           anim_en, anim_rst, flip,
    output pixel_addr, is_object, frame_idx
  );
endinterface

// File: rtl/sprite_renderer.sv
// sprite_renderer: converts the VGA scan position into a sprite-sheet ROM
// address and a hit flag for one sprite. Two-stage pipeline (latency 2,
// one pixel per clock). Placement and flip are shadowed on frame_tick so a
// mid-frame update never tears; animation steps every FRAME_DIV ticks.
// Optional feature macro: SPRITE_FLIP_EN (horizontal mirroring). When it is
// undefined the flip input is ignored and no mirror logic is built.
module sprite_renderer #(
  parameter int SPR_W       = 10,
  parameter int SPR_H       = 10,
  parameter int N_FRAMES    = 8,
  parameter int FRAME_DIV   = 6,
  parameter int SHEET_W     = 360,
  parameter int SHEET_DEPTH = 86400,
  parameter int ADDR_W      = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  sprite_renderer_if.slave   bus
);

  localparam int FIDX_W = (N_FRAMES  > 1) ? $clog2(N_FRAMES)  : 1;
  localparam int DIV_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  // Headroom over ADDR_W so (base_y+oy)*SHEET_W never overflows before the modulo.
  localparam int RAW_W  = ADDR_W + 4;

  // Reduce a raw sheet offset into the ROM address range.
  function automatic logic [ADDR_W-1:0] wrap_addr(input logic [RAW_W-1:0] raw);
    logic [RAW_W-1:0] m;
    m = raw % RAW_W'(SHEET_DEPTH);
    return m[ADDR_W-1:0];
  endfunction

  // Frame-synchronous shadow copies of the placement inputs.
  logic [8:0] sx_q, sy_q, bx_q, by_q;

  // Animation state.
  logic [DIV_W-1:0]  div_q,  div_d;
  logic [FIDX_W-1:0] fidx_q, fidx_d;

  // Stage 1 next-state and registers.
  logic              hit_p1_d, hit_p1_q;
  logic [8:0]        dx_p1_d,  dx_p1_q;
  logic [8:0]        oy_p1_d,  oy_p1_q;
  logic [FIDX_W-1:0] fidx_p1_q;

  // Stage 2 next-state and output registers.
  logic [RAW_W-1:0]  raw_p2;
  logic [ADDR_W-1:0] addr_p2_d, addr_p2_q;
  logic              obj_p2_q;

  // Scan position in half-res coordinates; the LSBs only select sub-pixels.
  logic [8:0] x, y;
  logic [8:0] ox;
  logic       unused_lsb;
  assign x          = bus.h_cnt[9:1];
  assign y          = bus.v_cnt[9:1];
  assign unused_lsb = bus.h_cnt[0] ^ bus.v_cnt[0];

`ifdef SPRITE_FLIP_EN
  logic flip_q;

  // Shadow the mirror control together with the placement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              flip_q <= 1'b0;
    else if (bus.frame_tick) flip_q <= bus.flip;
  end
`else
  logic unused_flip;
  assign unused_flip = bus.flip;
`endif

  // Load the shadow placement registers at the start of vertical blank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_q <= '0;
      sy_q <= '0;
      bx_q <= '0;
      by_q <= '0;
    end else if (bus.frame_tick) begin
      sx_q <= bus.sprite_x;
      sy_q <= bus.sprite_y;
      bx_q <= bus.base_x;
      by_q <= bus.base_y;
    end
  end

  // Animation divider and frame counter; anim_rst wins over a same-cycle tick.
  always_comb begin
    div_d  = div_q;
    fidx_d = fidx_q;
    if (bus.anim_rst) begin
      div_d  = '0;
      fidx_d = '0;
    end else if (bus.frame_tick && bus.anim_en) begin
      if (div_q == DIV_W'(FRAME_DIV - 1)) begin
        div_d  = '0;
        fidx_d = (fidx_q == FIDX_W'(N_FRAMES - 1)) ? '0 : fidx_q + FIDX_W'(1);
      end else begin
        div_d  = div_q + DIV_W'(1);
      end
    end
  end

  // Animation state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      fidx_q <= '0;
    end else begin
      div_q  <= div_d;
      fidx_q <= fidx_d;
    end
  end

  // ---- stage 1: hit test and sprite-local offsets ----
  // Hit test on zero-extended 10-bit operands so sx+SPR_W never wraps at the edge.
  always_comb begin
    logic [9:0] x_e, y_e, sx_e, sy_e;
    x_e      = {1'b0, x};
    y_e      = {1'b0, y};
    sx_e     = {1'b0, sx_q};
    sy_e     = {1'b0, sy_q};
    hit_p1_d = (x_e >= sx_e) && (x_e < sx_e + 10'(SPR_W)) &&
               (y_e >= sy_e) && (y_e < sy_e + 10'(SPR_H));
    ox       = x - sx_q;
    oy_p1_d  = y - sy_q;
`ifdef SPRITE_FLIP_EN
    dx_p1_d  = flip_q ? (9'(SPR_W - 1) - ox) : ox;
`else
    dx_p1_d  = ox;
`endif
  end

  // Stage 1 pipeline register, including a snapshot of the current frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_p1_q  <= 1'b0;
      dx_p1_q   <= '0;
      oy_p1_q   <= '0;
      fidx_p1_q <= '0;
    end else begin
      hit_p1_q  <= hit_p1_d;
      dx_p1_q   <= dx_p1_d;
      oy_p1_q   <= oy_p1_d;
      fidx_p1_q <= fidx_q;
    end
  end

  // ---- stage 2: sheet address ----
  // Row from base_y+oy, column from base_x + frame strip offset + dx; zero on miss.
  always_comb begin
    raw_p2    = (RAW_W'(by_q) + RAW_W'(oy_p1_q)) * RAW_W'(SHEET_W)
              + RAW_W'(bx_q)
              + RAW_W'(fidx_p1_q) * RAW_W'(SPR_W)
              + RAW_W'(dx_p1_q);
    addr_p2_d = hit_p1_q ? wrap_addr(raw_p2) : '0;
  end

  // Stage 2 output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_p2_q <= '0;
      obj_p2_q  <= 1'b0;
    end else begin
      addr_p2_q <= addr_p2_d;
      obj_p2_q  <= hit_p1_q;
    end
  end

  assign bus.pixel_addr = addr_p2_q;
  assign bus.is_object  = obj_p2_q;
  assign bus.frame_idx  = fidx_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// tb_sprite_renderer: directed vector table for the hit/address path plus
// hand-written sequences for animation, flip, modulo wrap, shadowing and reset.
module tb_sprite_renderer;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  sprite_renderer_if #(.ADDR_W(17), .FIDX_W(3)) bus ();

  sprite_renderer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int sx; int sy; int bx; int by;
    int h;  int v;
    int addr; int obj;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One frame_tick pulse; starts and ends on a falling edge.
  task automatic tick();
    @(negedge clk);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic place(input int sx, input int sy, input int bx, input int by);
    bus.sprite_x = 9'(sx);
    bus.sprite_y = 9'(sy);
    bus.base_x   = 9'(bx);
    bus.base_y   = 9'(by);
  endtask

  // Present a scan position and sample the outputs two clocks later.
  task automatic probe(input int h, input int v, output int addr, output int obj);
    bus.h_cnt = 10'(h);
    bus.v_cnt = 10'(v);
    repeat (2) @(negedge clk);
    addr = int'(bus.pixel_addr);
    obj  = int'(bus.is_object);
  endtask

  vec_t vt[12];
  int   a, o;
  int   exp_flip0, exp_flip1;

  initial begin
    n_vec = 0;
    n_err = 0;

    vt[0]  = '{100, 50,  0, 0, 200, 100,    0, 1};
    vt[1]  = '{100, 50,  0, 0, 218, 118, 3249, 1};
    vt[2]  = '{100, 50,  0, 0, 220, 100,    0, 0};
    vt[3]  = '{100, 50,  0, 0, 199, 100,    0, 0};
    vt[4]  = '{100, 50,  0, 0, 202, 101,    1, 1};
    vt[5]  = '{100, 50,  0, 0, 200, 120,    0, 0};
    vt[6]  = '{315,  0,  0, 0,   0,   0,    0, 0};
    vt[7]  = '{315,  0,  0, 0,   8,   0,    0, 0};
    vt[8]  = '{315,  0,  0, 0, 630,   0,    0, 1};
    vt[9]  = '{315,  0,  0, 0, 639,   2,  364, 1};
    vt[10] = '{ 10, 10,  5, 3,  24,  26, 2167, 1};
    vt[11] = '{ 10, 10,  5, 3,  18,  26,    0, 0};

    rst_n          = 1'b0;
    bus.frame_tick = 1'b0;
    bus.h_cnt      = '0;
    bus.v_cnt      = '0;
    bus.anim_en    = 1'b0;
    bus.anim_rst   = 1'b0;
    bus.flip       = 1'b0;
    place(0, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("reset_addr",  int'(bus.pixel_addr), 0);
    chk("reset_obj",   int'(bus.is_object),  0);
    chk("reset_frame", int'(bus.frame_idx),  0);
    rst_n = 1'b1;

    // Table: load placement on a tick (animation frozen at 0), then probe.
    for (int i = 0; i < 12; i++) begin
      place(vt[i].sx, vt[i].sy, vt[i].bx, vt[i].by);
      tick();
      probe(vt[i].h, vt[i].v, a, o);
      chk($sformatf("vec%0d_addr", i), a, vt[i].addr);
      chk($sformatf("vec%0d_obj", i),  o, vt[i].obj);
    end

    // Horizontal mirror.
`ifdef SPRITE_FLIP_EN
    exp_flip0 = 9;
    exp_flip1 = 3240;
`else
    exp_flip0 = 0;
    exp_flip1 = 3249;
`endif
    place(100, 50, 0, 0);
    bus.flip = 1'b1;
    tick();
    probe(200, 100, a, o);
    chk("flip_origin_addr", a, exp_flip0);
    chk("flip_origin_obj",  o, 1);
    probe(218, 118, a, o);
    chk("flip_corner_addr", a, exp_flip1);
    bus.flip = 1'b0;
    tick();

    // Animation divider and frame counter.
    bus.anim_en = 1'b1;
    repeat (5) tick();
    chk("anim_5ticks_frame", int'(bus.frame_idx), 0);
    tick();
    chk("anim_6ticks_frame", int'(bus.frame_idx), 1);
    probe(200, 100, a, o);
    chk("anim_frame1_addr", a, 10);
    repeat (42) tick();
    chk("anim_48ticks_frame", int'(bus.frame_idx), 0);
    repeat (18) tick();
    chk("anim_frame3", int'(bus.frame_idx), 3);
    repeat (2) tick();
    chk("anim_frame3_div2", int'(bus.frame_idx), 3);
    @(negedge clk);
    bus.anim_rst   = 1'b1;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.anim_rst   = 1'b0;
    bus.frame_tick = 1'b0;
    chk("anim_rst_frame", int'(bus.frame_idx), 0);
    repeat (5) tick();
    chk("anim_rst_div_5ticks", int'(bus.frame_idx), 0);
    tick();
    chk("anim_rst_div_6ticks", int'(bus.frame_idx), 1);

    // Modulo wrap at the last frame.
    repeat (36) tick();
    chk("mod_frame7", int'(bus.frame_idx), 7);
    bus.anim_en = 1'b0;
    place(100, 50, 350, 239);
    tick();
    chk("mod_frame_hold", int'(bus.frame_idx), 7);
    probe(200, 100, a, o);
    chk("mod_addr", a, 60);
    chk("mod_obj",  o, 1);

    // Shadowing: a mid-frame move is ignored until the next tick.
    place(100, 50, 0, 0);
    @(negedge clk);
    bus.anim_rst   = 1'b1;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.anim_rst   = 1'b0;
    bus.frame_tick = 1'b0;
    bus.sprite_x   = 9'd150;
    probe(200, 100, a, o);
    chk("shadow_old_obj",  o, 1);
    chk("shadow_old_addr", a, 0);
    probe(300, 100, a, o);
    chk("shadow_new_early_obj", o, 0);
    tick();
    probe(300, 100, a, o);
    chk("shadow_new_obj", o, 1);
    probe(200, 100, a, o);
    chk("shadow_old_gone_obj", o, 0);

    // Asynchronous reset in the middle of a line.
    bus.anim_en = 1'b1;
    repeat (6) tick();
    bus.anim_en = 1'b0;
    probe(300, 100, a, o);
    chk("prerst_addr", a, 10);
    chk("prerst_obj",  o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_addr",  int'(bus.pixel_addr), 0);
    chk("midrst_obj",   int'(bus.is_object),  0);
    chk("midrst_frame", int'(bus.frame_idx),  0);
    bus.h_cnt = 10'd4;
    bus.v_cnt = 10'd2;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_1clk_obj", int'(bus.is_object), 0);
    @(negedge clk);
    chk("postrst_2clk_obj",  int'(bus.is_object),  1);
    chk("postrst_2clk_addr", int'(bus.pixel_addr), 362);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
